mode_pause_controller: RTL and testbench

//   Front-end control stage feeding the mode processors (mode 1..4 LED engines).

---
 rtl/mode_pause_controller.sv | 164 ++++++++++++++++
 tb/tb_mode_pause_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mode_pause_controller.sv
// Button front-end for the mode LED engines: sync/debounce, pause, mode, tick.
// Build option: define TICK_HOLD_ON_PAUSE_EN to freeze the tick divider while paused.

module mode_pause_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);
    localparam int              CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          w_diff;
    logic          w_done;

    assign w_diff  = r_sync[1] ^ r_level;
    assign w_done  = w_diff && (r_cnt == LAST);
    assign o_press = r_press;

    // Two-flop synchroniser for the raw, asynchronous button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    // Count consecutive differing samples; the last one flips the level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= w_done & r_sync[1];
            if (w_done) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end
endmodule

module mode_pause_controller #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int N_MODES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_pause,
    input  logic       btn_mode,
    output logic       tick,
    output logic       pause,
    output logic [1:0] mode,
    output logic       mode_clr
);
    localparam int            TW     = $clog2(TICK_DIV);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
    localparam logic [1:0]    M_LAST = 2'(N_MODES - 1);

    logic          w_pause_press;
    logic          w_mode_press;
    logic          w_wrap;

    logic          r_pause;
    logic [1:0]    r_mode;
    logic          r_clr;
    logic          r_tick;
    logic [TW-1:0] r_cnt;

    logic          w_pause_nxt;
    logic [1:0]    w_mode_nxt;
    logic          w_clr_nxt;
    logic          w_tick_nxt;
    logic [TW-1:0] w_cnt_nxt;

    mode_pause_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_pause (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_pause),
        .o_press (w_pause_press)
    );

    mode_pause_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_mode (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_mode),
        .o_press (w_mode_press)
    );

    assign w_wrap   = (r_cnt == T_LAST);
    assign tick     = r_tick;
    assign pause    = r_pause;
    assign mode     = r_mode;
    assign mode_clr = r_clr;

    // Next state: divider advance, then button actions; mode press overrides all.
    always_comb begin
        w_pause_nxt = r_pause;
        w_mode_nxt  = r_mode;
        w_clr_nxt   = 1'b0;
        w_tick_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
`ifdef TICK_HOLD_ON_PAUSE_EN
        if (!r_pause) begin
            if (w_wrap) begin
                w_cnt_nxt  = '0;
                w_tick_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + TW'(1);
            end
        end
`else
        if (w_wrap) begin
            w_cnt_nxt  = '0;
            w_tick_nxt = 1'b1;
        end else begin
            w_cnt_nxt = r_cnt + TW'(1);
        end
`endif
        if (w_mode_press) begin
            w_mode_nxt  = (r_mode == M_LAST) ? 2'd0 : r_mode + 2'd1;
            w_clr_nxt   = 1'b1;
            w_pause_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_tick_nxt  = 1'b0;
        end else if (w_pause_press) begin
            w_pause_nxt = ~r_pause;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pause <= 1'b0;
            r_mode  <= 2'd0;
            r_clr   <= 1'b0;
            r_tick  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_pause <= w_pause_nxt;
            r_mode  <= w_mode_nxt;
            r_clr   <= w_clr_nxt;
            r_tick  <= w_tick_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_mode_pause_controller.sv
// Bench for mode_pause_controller: table of button presses plus
// hand-written sequences for latency, pause hold and reset corner cases.
`timescale 1ns/1ps
module tb_mode_pause_controller;
    localparam int TD = 8;
    localparam int DB = 4;
    localparam int NM = 4;
`ifdef TICK_HOLD_ON_PAUSE_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic       bp;
        logic       bm;
        int         width;
        logic       ep;
        logic [1:0] em;
        int         eclr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_mode = 1'b0;
    logic       tick;
    logic       pause;
    logic [1:0] mode;
    logic       mode_clr;

    int   tests = 0;
    int   fails = 0;
    int   n_overlap = 0;
    int   nclr_idle;
    int   e_at, p_at, r_at, tp, ft;
    logic prev;
    vec_t vt [12];

    mode_pause_controller #(
        .TICK_DIV  (TD),
        .DB_CYCLES (DB),
        .N_MODES   (NM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_pause (btn_pause),
        .btn_mode  (btn_mode),
        .tick      (tick),
        .pause     (pause),
        .mode      (mode),
        .mode_clr  (mode_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick && mode_clr) n_overlap++;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int id);
        int nclr;
        int clr_at;
        int gap;
        nclr   = 0;
        clr_at = -1;
        gap    = -1;
        btn_pause = v.bp;
        btn_mode  = v.bm;
        for (int s = 1; s <= v.width + 20; s++) begin
            step(1);
            if (s == v.width) begin
                btn_pause = 1'b0;
                btn_mode  = 1'b0;
            end
            if (mode_clr) begin
                nclr++;
                clr_at = s;
            end else if (tick && clr_at >= 0 && gap < 0) begin
                gap = s - clr_at;
            end
        end
        chk($sformatf("vec%0d_pause", id), int'(pause), int'(v.ep));
        chk($sformatf("vec%0d_mode", id), int'(mode), int'(v.em));
        chk($sformatf("vec%0d_clr", id), nclr, v.eclr);
        if (v.eclr > 0) chk($sformatf("vec%0d_tickgap", id), gap, TD);
    endtask

    initial begin
        vt[0]  = '{1'b0, 1'b1, 10, 1'b0, 2'd1, 1};
        vt[1]  = '{1'b0, 1'b1, 10, 1'b0, 2'd2, 1};
        vt[2]  = '{1'b0, 1'b1, 10, 1'b0, 2'd3, 1};
        vt[3]  = '{1'b0, 1'b1, 10, 1'b0, 2'd0, 1};
        vt[4]  = '{1'b0, 1'b1, 10, 1'b0, 2'd1, 1};
        vt[5]  = '{1'b1, 1'b0, 10, 1'b1, 2'd1, 0};
        vt[6]  = '{1'b1, 1'b1, 10, 1'b0, 2'd2, 1};
        vt[7]  = '{1'b1, 1'b0, 3,  1'b0, 2'd2, 0};
        vt[8]  = '{1'b0, 1'b1, 3,  1'b0, 2'd2, 0};
        vt[9]  = '{1'b1, 1'b0, 10, 1'b1, 2'd2, 0};
        vt[10] = '{1'b0, 1'b1, 10, 1'b0, 2'd3, 1};
        vt[11] = '{1'b1, 1'b0, 40, 1'b1, 2'd3, 0};

        // reset state
        step(3);
        chk("rst_tick", int'(tick), 0);
        chk("rst_pause", int'(pause), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_clr", int'(mode_clr), 0);

        // idle ticks at 8,16,24,32 after release
        reset = 1'b1;
        nclr_idle = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            chk("idle_tick", int'(tick), (k % TD == 0) ? 1 : 0);
            if (mode_clr) nclr_idle++;
        end
        chk("idle_pause", int'(pause), 0);
        chk("idle_mode", int'(mode), 0);
        chk("idle_clr", nclr_idle, 0);

        // pause press latency DB+3
        btn_pause = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k <= 8) chk("pause_lat", int'(pause), (k >= DB + 3) ? 1 : 0);
        end
        btn_pause = 1'b0;
        step(15);
        chk("pause_held", int'(pause), 1);
        btn_pause = 1'b1;
        step(20);
        btn_pause = 1'b0;
        step(15);
        chk("pause_again", int'(pause), 0);

        for (int i = 0; i < 12; i++) apply(vt[i], i);

        // pause at divider count 3, held 50 clocks, then resumed
        e_at = -1; p_at = -1; r_at = -1; tp = 0; ft = -1;
        prev = pause;
        btn_mode = 1'b1;
        for (int s = 1; s <= 90; s++) begin
            step(1);
            if (s == 3) btn_pause = 1'b1;
            if (s == 15) begin
                btn_pause = 1'b0;
                btn_mode  = 1'b0;
            end
            if (s == 53) btn_pause = 1'b1;
            if (s == 65) btn_pause = 1'b0;
            if (mode_clr) e_at = s;
            if (e_at >= 0 && !prev && pause && p_at < 0) p_at = s;
            if (p_at >= 0 && prev && !pause && r_at < 0) r_at = s;
            if (tick && pause && p_at >= 0 && r_at < 0) tp++;
            if (tick && r_at >= 0 && s > r_at && ft < 0) ft = s - r_at;
            prev = pause;
        end
        chk("hold_clr_at", e_at, 7);
        chk("hold_pause_at", p_at, 10);
        chk("hold_resume_at", r_at, 60);
        chk("hold_ticks_paused", tp, HOLD ? 0 : 6);
        chk("hold_first_tick", ft, HOLD ? 5 : 3);
        chk("hold_mode", int'(mode), 0);

        apply('{1'b0, 1'b1, 10, 1'b0, 2'd1, 1}, 12);
        apply('{1'b1, 1'b0, 10, 1'b1, 2'd1, 0}, 13);

        // reset mid-debounce and mid-period
        btn_mode = 1'b1;
        step(4);
        reset = 1'b0;
        #1;
        chk("midrst_tick", int'(tick), 0);
        chk("midrst_pause", int'(pause), 0);
        chk("midrst_mode", int'(mode), 0);
        chk("midrst_clr", int'(mode_clr), 0);
        step(3);
        reset = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (k == 20) btn_mode = 1'b0;
            chk("post_rst_mode", int'(mode), (k >= 7) ? 1 : 0);
            chk("post_rst_clr", int'(mode_clr), (k == 7) ? 1 : 0);
            chk("post_rst_tick", int'(tick), (k == 15 || k == 23) ? 1 : 0);
        end
        chk("post_rst_pause", int'(pause), 0);

        chk("tick_clr_overlap", n_overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
